mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter in front of the single-port instruction/data RAM inside the SoC memory controller. Shares the RAM between the instruction-fetch port (IF) and the load/store port (LS). Arbitration is fixed-priority LS with a starvation guard for IF. Sequences exactly one RAM transaction at a time and returns a one-cycle response pulse to the winner.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of both request ports
- DATA_W, 32, data width; byte strobes are DATA_W/8 wide
- RAM_AW, 12, RAM word-address width
- RAM_LAT, 1, RAM read latency in cycles (≥1)
- STARVE_MAX, 4, consecutive contested LS grants before IF is forced

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  ADDR_W  fetch byte address
- if_rsp_valid  out  1  fetch data valid (1-cycle pulse)
- if_rsp_data  out  DATA_W  fetched word
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store accepted this cycle
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  load/store byte address
- ls_wdata  in  DATA_W  store data
- ls_wstrb  in  DATA_W/8  store byte enables
- ls_rsp_valid  out  1  load data / store ack (1-cycle pulse)
- ls_rsp_data  out  DATA_W  load data; 0 for stores
- ram_en  out  1  RAM access strobe
- ram_we  out  DATA_W/8  RAM byte write enables
- ram_addr  out  RAM_AW  RAM word address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid RAM_LAT cycles after the ram_en cycle

## Operation
- FSM: IDLE → CMD → WAIT → RSP → IDLE.
- IDLE: req_ready is high only for the selected requester, and only in IDLE. The handshake completes at the edge where valid&ready are both high. At that edge, latch the winner ID and drive the ram_* registers.
- Selection when both requesters are valid:
  - LS wins if starve_cnt < STARVE_MAX; otherwise IF wins.
  - If only one requester is valid, that one wins.
- starve_cnt:
  - Increments on an LS grant while if_req_valid is high (saturates at STARVE_MAX).
  - Clears on any IF grant, and in any IDLE cycle where if_req_valid is low.
- CMD: ram_en=1 for exactly one cycle.
  - ram_addr = addr[RAM_AW+1:2]; upper address bits are ignored, so addresses wrap modulo RAM depth.
  - IF requests: ram_we=0.
  - LS store: ram_we=ls_wstrb, ram_wdata=ls_wdata.
  - LS load: ram_we=0.
- WAIT: count RAM_LAT cycles. On the last one, capture ram_rdata into the winner's rsp_data (0 for stores).
- RSP: the winner's rsp_valid=1 for exactly one cycle; the loser's stays 0. Then return to IDLE.
- A store with wstrb=0 writes nothing but is still acknowledged.
- Requesters must hold valid/addr/wdata stable until ready; the block does not check this.
- Reset asserted mid-transaction: immediately return to IDLE and clear starve_cnt. The in-flight response is dropped and no rsp_valid is produced.

## Timing
- Reset values: all outputs 0, state IDLE, starve_cnt 0.
- Acceptance edge E0: ram_en is high during the cycle after E0.
- rsp_valid is high during the cycle after edge E0+RAM_LAT+1, i.e. RAM_LAT+2 cycles after E0.
- Next req_ready is high RAM_LAT+3 cycles after E0. Peak throughput is one transaction per RAM_LAT+3 cycles (4 at default).
- ram_* outputs are registered. req_ready is combinational from state, valids and starve_cnt.

## Structure
- Shared package mem_arb_pkg holds:
  - FSM state encodings (IDLE/CMD/WAIT/RSP)
  - grant IDs (GNT_IF=0, GNT_LS=1)
  - default RAM_LAT and STARVE_MAX constants
- One natural sub-module: mem_arb_sel, the combinational priority select plus the starve_cnt register.
- mem_arbiter instantiates mem_arb_sel and implements the FSM and datapath.

## Test plan
- Reset/idle: rst=0 for 3 cycles, then release with no requests → all outputs stay 0, if_req_ready=ls_req_ready=0 until a request appears.
- IF-only read: preload word 3 with 0x00500093; if_addr=0x0C → ram_addr=3, if_rsp_data=0x00500093 with if_rsp_valid pulsing 3 cycles after acceptance.
- Partial store then load: store 0xAABBCCDD to 0x10 with wstrb=4'b0011 over 0x11111111 → load of 0x10 returns 0x1111CCDD. A store with wstrb=0 is acked and memory is unchanged.
- Starvation: IF and LS both held valid continuously → grant order is LS,LS,LS,LS,IF,LS,...; IF is granted on the 5th arbitration.
- Wrap: if_addr=0x4000+0x0C with RAM_AW=12 → ram_addr=3, same data as 0x0C.
- Reset mid-op: assert rst during WAIT of a load → no ls_rsp_valid; after release, a new request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/LS memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } gnt_t;

  localparam int unsigned DEF_RAM_LAT    = 1;
  localparam int unsigned DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_arb_sel.sv
// Fixed-priority LS/IF select with a starvation guard that forces IF
// after STARVE_MAX consecutive contested LS grants.
module mem_arb_sel
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic if_valid,
  input  logic ls_valid,
  output gnt_t gnt,
  output logic if_ready,
  output logic ls_ready
);

  localparam int unsigned    CW      = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;

  // Priority select: LS unless IF has waited through STARVE_MAX LS grants.
  always_comb begin
    gnt = GNT_IF;
    if (ls_valid && (!if_valid || (starve_cnt < CNT_MAX))) begin
      gnt = GNT_LS;
    end
    if_ready = idle && if_valid && (gnt == GNT_IF);
    ls_ready = idle && ls_valid && (gnt == GNT_LS);
  end

  // Count contested LS grants; clear on IF grant or when IF is not waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (idle) begin
      if (ls_ready && if_valid) begin
        if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + CW'(1);
      end else if (if_ready || !if_valid) begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sequencing one single-port RAM transaction at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RAM_AW     = 12,
  parameter int unsigned RAM_LAT    = DEF_RAM_LAT,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_data,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int unsigned   LW       = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(RAM_LAT - 1);

  state_t        state, state_next;
  gnt_t          gnt, owner;
  logic          idle, fire, is_store, wait_done;
  logic [LW-1:0] lat_cnt;

  // Byte offset and address bits above the RAM depth are dropped on purpose.
  logic addr_unused;
  assign addr_unused = ^{if_addr[ADDR_W-1:RAM_AW+2], if_addr[1:0],
                         ls_addr[ADDR_W-1:RAM_AW+2], ls_addr[1:0]};

  assign idle      = (state == ST_IDLE);
  assign fire      = if_req_ready | ls_req_ready;
  assign wait_done = (lat_cnt == LAT_LAST);

  mem_arb_sel #(
    .STARVE_MAX(STARVE_MAX)
  ) u_sel (
    .clk     (clk),
    .rst     (rst),
    .idle    (idle),
    .if_valid(if_req_valid),
    .ls_valid(ls_req_valid),
    .gnt     (gnt),
    .if_ready(if_req_ready),
    .ls_ready(ls_req_ready)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state: IDLE -> CMD -> WAIT (RAM_LAT cycles) -> RSP -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (fire) state_next = ST_CMD;
      ST_CMD:  state_next = ST_WAIT;
      ST_WAIT: if (wait_done) state_next = ST_RSP;
      ST_RSP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered RAM command, latency counter and response capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner        <= GNT_IF;
      is_store     <= 1'b0;
      lat_cnt      <= '0;
      ram_en       <= 1'b0;
      ram_we       <= '0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      ls_rsp_valid <= 1'b0;
      ls_rsp_data  <= '0;
    end else begin
      ram_en       <= 1'b0;
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fire) begin
            owner  <= gnt;
            ram_en <= 1'b1;
            if (gnt == GNT_LS) begin
              is_store  <= ls_we;
              ram_addr  <= ls_addr[RAM_AW+1:2];
              ram_we    <= ls_we ? ls_wstrb : '0;
              ram_wdata <= ls_we ? ls_wdata : '0;
            end else begin
              is_store  <= 1'b0;
              ram_addr  <= if_addr[RAM_AW+1:2];
              ram_we    <= '0;
              ram_wdata <= '0;
            end
          end
        end
        ST_CMD: begin
          ram_we  <= '0;
          lat_cnt <= '0;
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt + LW'(1);
          if (wait_done) begin
            if (owner == GNT_LS) begin
              ls_rsp_valid <= 1'b1;
              ls_rsp_data  <= is_store ? '0 : ram_rdata;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= ram_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 1-cycle RAM.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned ADDR_W = 32, DATA_W = 32, RAM_AW = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_addr, if_rsp_data;
  logic        ls_req_valid, ls_req_ready, ls_we, ls_rsp_valid;
  logic [31:0] ls_addr, ls_wdata, ls_rsp_data;
  logic [3:0]  ls_wstrb;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  typedef struct {
    bit          is_ls;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] mem [0:4095];
  logic        load_mem;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_AW(RAM_AW), .RAM_LAT(1), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM, read latency 1, byte-enabled writes.
  always @(posedge clk) begin
    if (load_mem) begin
      mem[3] <= 32'h0050_0093;
      mem[4] <= 32'h1111_1111;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic bound_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  // Monitor: every response pulse is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      if (if_rsp_valid && ls_rsp_valid) begin
        total++; bad++;
        $display("FAIL dual_rsp: got both valid want one");
      end else if (if_rsp_valid || ls_rsp_valid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp: got if=%b ls=%b want none", if_rsp_valid, ls_rsp_valid);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_port", {31'd0, ls_rsp_valid}, {31'd0, e.is_ls});
          check("rsp_data", ls_rsp_valid ? ls_rsp_data : if_rsp_data, e.data);
          check("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      bound_fail({name, " rsp"});
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Issue one request (called just after a negedge) and queue its response.
  task automatic do_req(input bit is_ls, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] exp_data, input logic [11:0] exp_ra,
                        input string name);
    int   n  = 0;
    bit   ok = 0;
    exp_t e;
    if (is_ls) begin
      ls_req_valid = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_wstrb = strb;
    end else begin
      if_req_valid = 1'b1; if_addr = addr;
    end
    while (n < 50) begin
      #1;
      if (is_ls ? ls_req_ready : if_req_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (!ok) begin
      bound_fail({name, " accept"});
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      return;
    end
    e.is_ls = is_ls; e.data = exp_data; e.cyc = cyc + 3;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    @(negedge clk);
    check({name, " ram_en"}, {31'd0, ram_en}, 32'd1);
    check({name, " ram_addr"}, {20'd0, ram_addr}, {20'd0, exp_ra});
    check({name, " ram_we"}, {28'd0, ram_we}, {28'd0, (is_ls && we) ? strb : 4'd0});
    if (is_ls && we) check({name, " ram_wdata"}, ram_wdata, wdata);
    drain(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_ls [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int n;

    rst = 1'b0; load_mem = 1'b1;
    if_req_valid = 1'b0; if_addr = '0;
    ls_req_valid = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;

    // Reset and idle.
    repeat (3) @(negedge clk);
    check("reset outs", {if_req_ready, ls_req_ready, ram_en, if_rsp_valid, ls_rsp_valid,
                         ram_we, ram_addr}, '0);
    check("reset data", if_rsp_data | ls_rsp_data | ram_wdata, '0);
    load_mem = 1'b0;
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle outs", {27'd0, if_req_ready, ls_req_ready, ram_en, if_rsp_valid, ls_rsp_valid}, '0);
    end

    do_req(1'b0, 1'b0, 32'h0000_000C, '0, 4'h0, 32'h0050_0093, 12'd3, "if_read");
    do_req(1'b1, 1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0011, 32'h0, 12'd4, "ls_store_part");
    do_req(1'b1, 1'b0, 32'h0000_0010, '0, 4'h0, 32'h1111_CCDD, 12'd4, "ls_load");
    do_req(1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0, 12'd4, "ls_store_nostrb");
    do_req(1'b1, 1'b0, 32'h0000_0010, '0, 4'h0, 32'h1111_CCDD, 12'd4, "ls_load_after0");
    do_req(1'b0, 1'b0, 32'h0000_400C, '0, 4'h0, 32'h0050_0093, 12'd3, "if_wrap");

    // Starvation: both held valid, expect LS x4 then IF then LS.
    if_req_valid = 1'b1; if_addr = 32'h0C;
    ls_req_valid = 1'b1; ls_we = 1'b0; ls_addr = 32'h10;
    for (int g = 0; g < 6; g++) begin
      exp_t e;
      n = 0;
      #1;
      while (!(if_req_ready || ls_req_ready) && n < 20) begin
        @(negedge clk); #1; n++;
      end
      if (n >= 20) begin
        bound_fail("starve grant");
        break;
      end
      check("single ready", {31'd0, if_req_ready & ls_req_ready}, 32'd0);
      check("grant order", {31'd0, ls_req_ready}, {31'd0, exp_ls[g]});
      e.is_ls = ls_req_ready;
      e.data  = ls_req_ready ? 32'h1111_CCDD : 32'h0050_0093;
      e.cyc   = cyc + 3;
      sb.push_back(e);
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    drain("starve");

    // Reset during WAIT of a load: response must be dropped.
    ls_req_valid = 1'b1; ls_we = 1'b0; ls_addr = 32'h10;
    n = 0;
    #1;
    while (!ls_req_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) bound_fail("midrst accept");
    @(posedge clk);
    #1;
    ls_req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst outs", {27'd0, ram_en, if_rsp_valid, ls_rsp_valid, if_req_ready, ls_req_ready}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("midrst no rsp", {31'd0, ls_rsp_valid}, 32'd0);
    end
    do_req(1'b1, 1'b0, 32'h0000_0010, '0, 4'h0, 32'h1111_CCDD, 12'd4, "after_rst_load");
    do_req(1'b0, 1'b0, 32'h0000_000C, '0, 4'h0, 32'h0050_0093, 12'd3, "after_rst_if");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
